// File: rtl/alu_regfile_sequencer.sv
// ---------------------------------------------------------------------------
// ALU_REGFILE_defs
//   Shared widths and ALU opcode encoding for the register-file/ALU datapath.
//
// alu_regfile_sequencer
//   Initiator-side command sequencer for the register-file/ALU datapath.
//   Accepts load-immediate and ALU-operation commands one at a time, drives
//   the datapath read addresses / opcode / carry and the register-file write
//   port, captures the ALU result and returns it over a response handshake.
//
//   Parameters
//     EXEC_WAIT      cycles the read addresses and opcode are held before
//                    ALU_Out is sampled (1..15)
//   Ports
//     Clock, Reset                  clock, synchronous active-high reset
//     Cmd_Valid / Cmd_Ready         command handshake
//     Cmd_Load                      1 = load immediate, 0 = ALU operation
//     Cmd_Imm                       immediate data for a load
//     Cmd_Src1 / Cmd_Src2 / Cmd_Dst operand and destination register addresses
//     Cmd_Opcode / Cmd_Carry        ALU operation and carry-in
//     Cmd_Writeback                 write the ALU result back to Cmd_Dst
//     Rsp_Valid / Rsp_Ready         response handshake
//     Rsp_Data                      captured ALU result (full ALU width)
//     Op_Count                      completed-command counter (wraps)
//     Read_Addr_1 / Read_Addr_2     datapath read addresses
//     Write_Addr / Write_enable /
//     Write_data                    register-file write port
//     Carry_In / Opcode             ALU controls
//     ALU_Out                       datapath result
// ---------------------------------------------------------------------------
package ALU_REGFILE_defs;
   localparam int REGFILE_WIDTH      = 16;
   localparam int REGFILE_ADDR_WIDTH = 4;
   localparam int ALU_OUTPUT_WIDTH   = 17;

   typedef enum logic [2:0] {
      ALU_ADD    = 3'd0,
      ALU_SUB    = 3'd1,
      ALU_AND    = 3'd2,
      ALU_OR     = 3'd3,
      ALU_XOR    = 3'd4,
      ALU_PASS_A = 3'd5
   } aluop_t;
endpackage

module alu_regfile_sequencer
   import ALU_REGFILE_defs::*;
#(
   parameter int EXEC_WAIT = 1
) (
   input  logic                          Clock,
   input  logic                          Reset,
   input  logic                          Cmd_Valid,
   output logic                          Cmd_Ready,
   input  logic                          Cmd_Load,
   input  logic [REGFILE_WIDTH-1:0]      Cmd_Imm,
   input  logic [REGFILE_ADDR_WIDTH-1:0] Cmd_Src1,
   input  logic [REGFILE_ADDR_WIDTH-1:0] Cmd_Src2,
   input  logic [REGFILE_ADDR_WIDTH-1:0] Cmd_Dst,
   input  aluop_t                        Cmd_Opcode,
   input  logic                          Cmd_Carry,
   input  logic                          Cmd_Writeback,
   output logic                          Rsp_Valid,
   input  logic                          Rsp_Ready,
   output logic [ALU_OUTPUT_WIDTH-1:0]   Rsp_Data,
   output logic [15:0]                   Op_Count,
   output logic [REGFILE_ADDR_WIDTH-1:0] Read_Addr_1,
   output logic [REGFILE_ADDR_WIDTH-1:0] Read_Addr_2,
   output logic [REGFILE_ADDR_WIDTH-1:0] Write_Addr,
   output logic                          Write_enable,
   output logic [REGFILE_WIDTH-1:0]      Write_data,
   output logic                          Carry_In,
   output aluop_t                        Opcode,
   input  logic [ALU_OUTPUT_WIDTH-1:0]   ALU_Out
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      EXEC = 3'd2,
      WB   = 3'd3,
      RESP = 3'd4
   } state_t;

   // Counter loads with EXEC_WAIT-1 so that zero marks the final EXEC cycle.
   localparam logic [3:0] EXEC_LAST = 4'(EXEC_WAIT - 1);

   state_t     state;
   logic [3:0] exec_cnt;
   logic       wb_q;

   // Ready is gated by Reset so it reads 0 in every reset cycle yet comes
   // back in the very first cycle after release, and no handshake can
   // complete while reset is asserted.
   assign Cmd_Ready = (state == IDLE) && !Reset;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state        <= IDLE;
         exec_cnt     <= '0;
         wb_q         <= 1'b0;
         Rsp_Valid    <= 1'b0;
         Rsp_Data     <= '0;
         Op_Count     <= '0;
         Read_Addr_1  <= '0;
         Read_Addr_2  <= '0;
         Write_Addr   <= '0;
         Write_enable <= 1'b0;
         Write_data   <= '0;
         Carry_In     <= 1'b0;
         Opcode       <= aluop_t'(0);
      end else begin
         unique case (state)
            IDLE: begin
               if (Cmd_Valid && Cmd_Ready) begin
                  // The datapath-facing registers double as the command
                  // field registers, so they hold until the next command.
                  Read_Addr_1 <= Cmd_Src1;
                  Read_Addr_2 <= Cmd_Src2;
                  Opcode      <= Cmd_Opcode;
                  Carry_In    <= Cmd_Carry;
                  Write_Addr  <= Cmd_Dst;
                  wb_q        <= Cmd_Writeback;
                  exec_cnt    <= EXEC_LAST;
                  if (Cmd_Load) begin
                     Write_data   <= Cmd_Imm;
                     Write_enable <= 1'b1;
                     state        <= LOAD;
                  end else begin
                     state        <= EXEC;
                  end
               end
            end

            LOAD: begin
               Write_enable <= 1'b0;
               Op_Count     <= Op_Count + 16'd1;
               state        <= IDLE;
            end

            EXEC: begin
               if (exec_cnt == 4'd0) begin
                  Rsp_Data <= ALU_Out;
                  if (wb_q) begin
                     // Same value as Rsp_Data low bits; any carry-out bit
                     // above the register width stays in Rsp_Data only.
                     Write_data   <= ALU_Out[REGFILE_WIDTH-1:0];
                     Write_enable <= 1'b1;
                     state        <= WB;
                  end else begin
                     Rsp_Valid <= 1'b1;
                     state     <= RESP;
                  end
               end else begin
                  exec_cnt <= exec_cnt - 4'd1;
               end
            end

            WB: begin
               Write_enable <= 1'b0;
               Rsp_Valid    <= 1'b1;
               state        <= RESP;
            end

            RESP: begin
               if (Rsp_Ready) begin
                  Rsp_Valid <= 1'b0;
                  Op_Count  <= Op_Count + 16'd1;
                  state     <= IDLE;
               end
            end

            default: begin
               Write_enable <= 1'b0;
               Rsp_Valid    <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_regfile_sequencer.md
# alu_regfile_sequencer

Command sequencer that drives the register-file/ALU datapath from its initiator side. It accepts load-immediate and ALU-operation commands over a valid/ready handshake. For each command it drives the datapath's read addresses, opcode, carry, and write port, captures the ALU result, and optionally writes that result back to the register file. It returns each ALU result over a second valid/ready handshake and sits between the upstream test/control logic and the ALU/register-file DUT.

## Interface
Widths and `aluop_t` come from `ALU_REGFILE_defs`. `REGFILE_WIDTH` = 16.

Parameters:
- `EXEC_WAIT`, default 1: number of cycles read addresses and opcode are held before `ALU_Out` is sampled. Legal range is 1..15.

Ports:
- `Clock`  in  1  system clock; all state updates on its rising edge
- `Reset`  in  1  synchronous, active-high reset
- `Cmd_Valid`  in  1  command valid
- `Cmd_Ready`  out  1  sequencer can accept a command
- `Cmd_Load`  in  1  1 = load immediate, 0 = ALU operation
- `Cmd_Imm`  in  REGFILE_WIDTH  immediate data for a load
- `Cmd_Src1`, `Cmd_Src2`  in  REGFILE_ADDR_WIDTH  ALU operand register addresses
- `Cmd_Dst`  in  REGFILE_ADDR_WIDTH  destination register
- `Cmd_Opcode`  in  aluop_t  ALU operation
- `Cmd_Carry`  in  1  carry-in for the operation
- `Cmd_Writeback`  in  1  write the ALU result to `Cmd_Dst`
- `Rsp_Valid`  out  1  result valid
- `Rsp_Ready`  in  1  downstream accepts the result
- `Rsp_Data`  out  ALU_OUTPUT_WIDTH  captured ALU result
- `Op_Count`  out  16  completed-command counter
- `Read_Addr_1`, `Read_Addr_2`  out  REGFILE_ADDR_WIDTH  to the datapath
- `Write_Addr`  out  REGFILE_ADDR_WIDTH; `Write_enable`  out  1; `Write_data`  out  REGFILE_WIDTH  register-file write port
- `Carry_In`  out  1; `Opcode`  out  aluop_t  ALU controls
- `ALU_Out`  in  ALU_OUTPUT_WIDTH  datapath result

## Operation
- FSM states are IDLE, LOAD, EXEC, WB, and RESP.
- **IDLE:**
  - `Cmd_Ready` = 1.
  - When `Cmd_Valid && Cmd_Ready`, all command fields are registered.
  - Next state is LOAD if `Cmd_Load`, otherwise EXEC.
- **LOAD:**
  - `Write_enable` = 1 for exactly one cycle, with `Write_Addr` = dst and `Write_data` = imm.
  - `Op_Count` increments; no response is generated.
  - Next state is IDLE.
- **EXEC:**
  - `Read_Addr_1`/`Read_Addr_2`/`Opcode`/`Carry_In` are driven from the registered src1/src2/opcode/carry.
  - The state lasts `EXEC_WAIT` cycles, tracked by a 4-bit down-counter.
  - On the last cycle, `ALU_Out` is registered into `Rsp_Data`.
  - Next state is WB if writeback is set, otherwise RESP.
- **WB:**
  - `Write_enable` = 1 for one cycle, with `Write_Addr` = dst and `Write_data` = `Rsp_Data[REGFILE_WIDTH-1:0]`.
  - If `ALU_OUTPUT_WIDTH` > `REGFILE_WIDTH`, the upper bits are dropped from the write but kept in `Rsp_Data`.
- **RESP:**
  - `Rsp_Valid` = 1, holding `Rsp_Data` stable until `Rsp_Ready`.
  - On the handshake, `Op_Count` increments and the next state is IDLE.
- **Write enable:** `Write_enable` = 0 in every state other than LOAD and WB.
- **Held outputs:**
  - The datapath address, opcode, and carry outputs hold the last registered command fields outside EXEC.
  - `Rsp_Data` holds its last value after the handshake.
- **One command at a time:** `Cmd_Ready` = 0 in every state except IDLE, so no command overlaps another. Any write completes before the next command's reads, which guarantees read-after-write ordering.
- **Counter wrap:** `Op_Count` wraps from 16'hFFFF to 0.
- **Reset:**
  - All outputs and state return to 0/IDLE, with `Opcode` set to `aluop_t'(0)`.
  - `Cmd_Ready` is 0 during the reset cycle and 1 in the first cycle after `Reset` deasserts.
- **Reset mid-command:** the command is abandoned, no further write occurs, and any pending response is dropped.

## Timing
- **Command acceptance:** a command is accepted at edge T.
- **Load:** `Write_enable` is high in cycle T+1; `Cmd_Ready` is high again in cycle T+2.
- **ALU operation:**
  - EXEC occupies cycles T+1 .. T+EXEC_WAIT, and `ALU_Out` is sampled at the end of cycle T+EXEC_WAIT.
  - Without writeback, `Rsp_Valid` rises in cycle T+EXEC_WAIT+1.
  - With writeback, `Write_enable` is high in cycle T+EXEC_WAIT+1 and `Rsp_Valid` rises in cycle T+EXEC_WAIT+2.
- **Throughput:** the minimum spacing between op commands with `EXEC_WAIT` = 1 is 3 cycles without writeback and 4 cycles with writeback, assuming `Rsp_Ready` is held high.
- **Response stall:** while `Rsp_Ready` is low, the FSM stays in RESP with all outputs stable; there is no timeout.
- **Reset priority:** `Reset` outranks every handshake in the same cycle.

## Test plan
- **Reset:** assert `Reset` for 2 cycles during an EXEC. Required: every output is 0, `Cmd_Ready` = 1 one cycle after release, no `Write_enable` pulse, and no `Rsp_Valid`.
- **Load then add:** load R1=16'h0005 and R2=16'h0003, then issue ADD (A+B+carry) with src1=1, src2=2, carry=1, dst=3, writeback=1. Required: `Rsp_Data` = 9, a write of 16'h0009 to address 3 occurs in cycle T+2, and `Rsp_Valid` rises in cycle T+3.
- **Dependent op:** immediately follow the add with ADD src1=3, src2=3, carry=0. Required: `Rsp_Data` = 18, which proves read-after-write ordering.
- **Response backpressure:** hold `Rsp_Ready`=0 for 5 cycles. Required: `Rsp_Valid`/`Rsp_Data` stay stable, `Cmd_Ready` = 0, and `Op_Count` increments only on the handshake.
- **Latency sweep:** run `EXEC_WAIT` = 3 with writeback=0. Required: `ALU_Out` is sampled after 3 EXEC cycles, `Rsp_Valid` rises in cycle T+4, and `Write_enable` never asserts.
- **Counter wrap:** preload `Op_Count` to 16'hFFFF by forcing it, then complete one load. Required: `Op_Count` = 0.
